// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths, grant encoding and writeback request type for the writeback arbiter
package wb_arbiter_pkg;
  localparam int XLEN = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  typedef enum logic {GRANT_PIPE = 1'b0, GRANT_LU = 1'b1} grant_t;
  typedef struct packed {
    logic valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: pipeline, long-latency, register file and decode-lookup signals of the writeback arbiter
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;
  logic pipe_valid, pipe_ready;
  logic [REG_ADDR_W-1:0] pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic lu_issue_valid, lu_issue_ready;
  logic [REG_ADDR_W-1:0] lu_issue_rd;
  logic lu_valid, lu_ready;
  logic [REG_ADDR_W-1:0] lu_rd;
  logic [XLEN-1:0] lu_data;
  logic we_regs;
  logic [REG_ADDR_W-1:0] w_regs_addr;
  logic [XLEN-1:0] w_regs_data;
  logic [REG_ADDR_W-1:0] rs1_addr, rs2_addr;
  logic rs1_busy, rs2_busy, rs1_fwd_valid, rs2_fwd_valid;
  logic [XLEN-1:0] rs1_fwd_data, rs2_fwd_data;
  modport master (
    output pipe_valid, pipe_rd, pipe_data, lu_issue_valid, lu_issue_rd, lu_valid, lu_rd, lu_data,
           rs1_addr, rs2_addr,
    input  pipe_ready, lu_issue_ready, lu_ready, we_regs, w_regs_addr, w_regs_data,
           rs1_busy, rs2_busy, rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_data, rs2_fwd_data
  );
  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, lu_issue_valid, lu_issue_rd, lu_valid, lu_rd, lu_data,
           rs1_addr, rs2_addr,
    output pipe_ready, lu_issue_ready, lu_ready, we_regs, w_regs_addr, w_regs_data,
           rs1_busy, rs2_busy, rs1_fwd_valid, rs2_fwd_valid, rs1_fwd_data, rs2_fwd_data
  );
endinterface

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: pending-destination vector for long-latency ops, issue gating and busy lookups
module wb_scoreboard
  import wb_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic issue_ready,
  input  logic clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic rs1_mask,
  input  logic rs2_mask,
  output logic rs1_busy,
  output logic rs2_busy
);
  logic [NUM_REGS-1:0] pending, set_vec, clr_vec;
  assign issue_ready = !pending[issue_rd];
  assign set_vec = (issue_valid && issue_ready && issue_rd != '0) ? NUM_REGS'(1) << issue_rd : '0;
  assign clr_vec = clr_valid ? NUM_REGS'(1) << clr_rd : '0;
  // set applied after clear so a same-cycle reissue of the retiring rd stays pending
  always_ff @(posedge clk or posedge rst)
    if (rst) pending <= '0;
    else pending <= (pending & ~clr_vec) | set_vec;
  assign rs1_busy = pending[rs1_addr] && !rs1_mask;
  assign rs2_busy = pending[rs2_addr] && !rs2_mask;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin merge of pipeline and long-latency results onto the register file write port.
// Define WB_ARB_BYPASS_EN to forward the current write to decode sources.
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input logic clk,
  input logic rst,
  wb_arbiter_if.slave bus
);
  wb_req_t hold, pipe_src;
  grant_t last_grant;
  logic grant_pipe, grant_lu, we, rs1_fwd, rs2_fwd;
  logic [REG_ADDR_W-1:0] wr_rd;
  logic [XLEN-1:0] wr_data;
  always_comb begin
    pipe_src = hold.valid ? hold : wb_req_t'{valid: bus.pipe_valid, rd: bus.pipe_rd, data: bus.pipe_data};
    grant_pipe = pipe_src.valid && (!bus.lu_valid || last_grant == GRANT_LU);
    grant_lu = bus.lu_valid && !grant_pipe;
    wr_rd = grant_pipe ? pipe_src.rd : grant_lu ? bus.lu_rd : '0;
    wr_data = grant_pipe ? pipe_src.data : grant_lu ? bus.lu_data : '0;
    we = (grant_pipe || grant_lu) && wr_rd != '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold <= '0;
      last_grant <= GRANT_LU;
    end else begin
      if (pipe_src.valid && bus.lu_valid) last_grant <= grant_lu ? GRANT_LU : GRANT_PIPE;
      if (hold.valid && grant_pipe) hold.valid <= 1'b0;
      else if (!hold.valid && bus.pipe_valid && !grant_pipe) hold <= pipe_src;
    end
  assign bus.pipe_ready = !hold.valid;
  assign bus.lu_ready = grant_lu;
  assign bus.we_regs = we;
  assign bus.w_regs_addr = we ? wr_rd : '0;
  assign bus.w_regs_data = we ? wr_data : '0;
`ifdef WB_ARB_BYPASS_EN
  assign rs1_fwd = we && wr_rd == bus.rs1_addr && bus.rs1_addr != '0;
  assign rs2_fwd = we && wr_rd == bus.rs2_addr && bus.rs2_addr != '0;
  assign bus.rs1_fwd_data = bus.w_regs_data;
  assign bus.rs2_fwd_data = bus.w_regs_data;
`else
  assign rs1_fwd = 1'b0;
  assign rs2_fwd = 1'b0;
  assign bus.rs1_fwd_data = '0;
  assign bus.rs2_fwd_data = '0;
`endif
  assign bus.rs1_fwd_valid = rs1_fwd;
  assign bus.rs2_fwd_valid = rs2_fwd;
  wb_scoreboard u_sb (
    .clk(clk),
    .rst(rst),
    .issue_valid(bus.lu_issue_valid),
    .issue_rd(bus.lu_issue_rd),
    .issue_ready(bus.lu_issue_ready),
    .clr_valid(grant_lu),
    .clr_rd(bus.lu_rd),
    .rs1_addr(bus.rs1_addr),
    .rs2_addr(bus.rs2_addr),
    .rs1_mask(rs1_fwd),
    .rs2_mask(rs2_fwd),
    .rs1_busy(bus.rs1_busy),
    .rs2_busy(bus.rs2_busy)
  );
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and random stimulus against a rule-level model of hold, round-robin and scoreboard
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  wb_arbiter_if bus();
  wb_arbiter dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  bit m_hold_v;
  logic [4:0] m_hold_rd;
  logic [63:0] m_hold_data;
  bit m_pipe_won_tie;
  bit m_pend [32];
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic idle_inputs();
    bus.pipe_valid = 0; bus.pipe_rd = 0; bus.pipe_data = 0;
    bus.lu_issue_valid = 0; bus.lu_issue_rd = 0;
    bus.lu_valid = 0; bus.lu_rd = 0; bus.lu_data = 0;
    bus.rs1_addr = 0; bus.rs2_addr = 0;
  endtask
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    m_hold_v = 0;
    m_pipe_won_tie = 0;
    foreach (m_pend[i]) m_pend[i] = 0;
    #2;
    chk("rst_pipe_ready", 64'(bus.pipe_ready), 64'd1);
    chk("rst_lu_ready", 64'(bus.lu_ready), 64'd0);
    chk("rst_we", 64'(bus.we_regs), 64'd0);
    chk("rst_addr", 64'(bus.w_regs_addr), 64'd0);
    chk("rst_data", bus.w_regs_data, 64'd0);
    chk("rst_busy", 64'({bus.rs1_busy, bus.rs2_busy}), 64'd0);
    chk("rst_issue_ready", 64'(bus.lu_issue_ready), 64'd1);
    chk("rst_fwd", 64'({bus.rs1_fwd_valid, bus.rs2_fwd_valid}) | bus.rs1_fwd_data | bus.rs2_fwd_data, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic step();
    bit p_has, pipe_wins, lu_wins, f1, f2, issue_ok;
    logic [4:0] exp_addr;
    logic [63:0] exp_data;
    #3;
    p_has = m_hold_v || bus.pipe_valid;
    pipe_wins = p_has && (!bus.lu_valid || !m_pipe_won_tie);
    lu_wins = bus.lu_valid && !pipe_wins;
    exp_addr = pipe_wins ? (m_hold_v ? m_hold_rd : bus.pipe_rd) : lu_wins ? bus.lu_rd : 5'd0;
    exp_data = pipe_wins ? (m_hold_v ? m_hold_data : bus.pipe_data) : lu_wins ? bus.lu_data : 64'd0;
    if (exp_addr == 0) exp_data = 0;
`ifdef WB_ARB_BYPASS_EN
    f1 = exp_addr != 0 && exp_addr == bus.rs1_addr;
    f2 = exp_addr != 0 && exp_addr == bus.rs2_addr;
`else
    f1 = 0;
    f2 = 0;
`endif
    chk("pipe_ready", 64'(bus.pipe_ready), 64'(!m_hold_v));
    chk("lu_ready", 64'(bus.lu_ready), 64'(lu_wins));
    chk("we_regs", 64'(bus.we_regs), 64'(exp_addr != 0));
    chk("w_addr", 64'(bus.w_regs_addr), 64'(exp_addr));
    chk("w_data", bus.w_regs_data, exp_data);
    chk("issue_ready", 64'(bus.lu_issue_ready), 64'(!m_pend[bus.lu_issue_rd]));
    chk("rs1_busy", 64'(bus.rs1_busy), 64'(m_pend[bus.rs1_addr] && !f1));
    chk("rs2_busy", 64'(bus.rs2_busy), 64'(m_pend[bus.rs2_addr] && !f2));
    chk("rs1_fwd_valid", 64'(bus.rs1_fwd_valid), 64'(f1));
    chk("rs2_fwd_valid", 64'(bus.rs2_fwd_valid), 64'(f2));
`ifdef WB_ARB_BYPASS_EN
    chk("rs1_fwd_data", bus.rs1_fwd_data, exp_data);
    chk("rs2_fwd_data", bus.rs2_fwd_data, exp_data);
`else
    chk("rs1_fwd_data", bus.rs1_fwd_data, 64'd0);
    chk("rs2_fwd_data", bus.rs2_fwd_data, 64'd0);
`endif
    issue_ok = bus.lu_issue_valid && !m_pend[bus.lu_issue_rd] && bus.lu_issue_rd != 0;
    @(posedge clk);
    if (p_has && bus.lu_valid) m_pipe_won_tie = pipe_wins;
    if (m_hold_v && pipe_wins) m_hold_v = 0;
    else if (!m_hold_v && bus.pipe_valid && !pipe_wins) begin
      m_hold_v = 1;
      m_hold_rd = bus.pipe_rd;
      m_hold_data = bus.pipe_data;
    end
    if (lu_wins) m_pend[bus.lu_rd] = 0;
    if (issue_ok) m_pend[bus.lu_issue_rd] = 1;
    #1;
  endtask
  initial begin
    do_reset();
    step();
    bus.pipe_valid = 1; bus.pipe_rd = 3; bus.pipe_data = 64'hAA;
    bus.lu_valid = 1; bus.lu_rd = 5; bus.lu_data = 64'hBB;
    #2 chk("tie1_addr", 64'(bus.w_regs_addr), 64'd3);
    chk("tie1_lu_ready", 64'(bus.lu_ready), 64'd0);
    step();
    bus.pipe_valid = 0;
    #2 chk("tie1_lu_addr", 64'(bus.w_regs_addr), 64'd5);
    chk("tie1_lu_data", bus.w_regs_data, 64'hBB);
    step();
    bus.pipe_valid = 1; bus.pipe_rd = 6; bus.pipe_data = 64'h66;
    bus.lu_rd = 8; bus.lu_data = 64'h88;
    #2 chk("tie2_lu_wins", 64'(bus.w_regs_addr), 64'd8);
    step();
    bus.lu_valid = 0; bus.pipe_rd = 10; bus.pipe_data = 64'h10;
    #2 chk("hold_ready", 64'(bus.pipe_ready), 64'd0);
    chk("hold_drain", bus.w_regs_data, 64'h66);
    step();
    #2 chk("after_hold_addr", 64'(bus.w_regs_addr), 64'd10);
    step();
    bus.pipe_valid = 0;
    bus.lu_issue_valid = 1; bus.lu_issue_rd = 7; bus.rs1_addr = 7;
    #2 chk("x7_not_yet_busy", 64'(bus.rs1_busy), 64'd0);
    step();
    #2 chk("x7_busy", 64'(bus.rs1_busy), 64'd1);
    chk("x7_reissue_blocked", 64'(bus.lu_issue_ready), 64'd0);
    step();
    bus.lu_issue_valid = 0;
    bus.lu_valid = 1; bus.lu_rd = 7; bus.lu_data = 64'h77;
    step();
    bus.lu_valid = 0;
    #2 chk("x7_cleared", 64'(bus.rs1_busy), 64'd0);
    step();
    bus.lu_issue_valid = 1; bus.lu_issue_rd = 9; bus.rs1_addr = 9;
    bus.lu_valid = 1; bus.lu_rd = 9; bus.lu_data = 64'h99;
    step();
    idle_inputs(); bus.rs1_addr = 9;
    #2 chk("x9_set_wins", 64'(bus.rs1_busy), 64'd1);
    step();
    bus.lu_issue_valid = 1; bus.lu_issue_rd = 0; bus.rs1_addr = 0;
    step();
    bus.lu_issue_valid = 0;
    #2 chk("x0_never_busy", 64'(bus.rs1_busy), 64'd0);
    bus.pipe_valid = 1; bus.pipe_rd = 0; bus.pipe_data = 64'h5;
    #1 chk("x0_write_we", 64'(bus.we_regs), 64'd0);
    step();
    bus.pipe_valid = 0;
    #2 chk("x0_handshake", 64'(bus.pipe_ready), 64'd1);
    bus.lu_issue_valid = 1; bus.lu_issue_rd = 4;
    step();
    bus.lu_issue_valid = 0;
    bus.lu_valid = 1; bus.lu_rd = 4; bus.lu_data = 64'h1234; bus.rs2_addr = 4;
`ifdef WB_ARB_BYPASS_EN
    #2 chk("byp_fwd_valid", 64'(bus.rs2_fwd_valid), 64'd1);
    chk("byp_fwd_data", bus.rs2_fwd_data, 64'h1234);
    chk("byp_busy", 64'(bus.rs2_busy), 64'd0);
`else
    #2 chk("nobyp_busy", 64'(bus.rs2_busy), 64'd1);
    chk("nobyp_fwd", 64'(bus.rs2_fwd_valid) | bus.rs2_fwd_data, 64'd0);
`endif
    step();
    idle_inputs();
    bus.pipe_valid = 1; bus.pipe_rd = 11; bus.pipe_data = 64'hB1;
    bus.lu_valid = 1; bus.lu_rd = 12; bus.lu_data = 64'hC2;
    step();
    bus.pipe_rd = 13; bus.pipe_data = 64'hD3;
    step();
    #1 chk("midhold_ready", 64'(bus.pipe_ready), 64'd0);
    do_reset();
    step();
    repeat (400) begin
      bus.pipe_valid = ($urandom_range(0, 9) < 6);
      bus.pipe_rd = 5'($urandom_range(0, 15));
      bus.pipe_data = {$urandom, $urandom};
      bus.lu_issue_valid = ($urandom_range(0, 2) == 0);
      bus.lu_issue_rd = 5'($urandom_range(0, 15));
      bus.lu_valid = ($urandom_range(0, 9) < 4);
      bus.lu_rd = 5'($urandom_range(0, 15));
      bus.lu_data = {$urandom, $urandom};
      bus.rs1_addr = 5'($urandom_range(0, 15));
      bus.rs2_addr = 5'($urandom_range(0, 15));
      step();
    end
    idle_inputs();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
